imm_gen_pipe: RTL

Pipelined, handshaked immediate generator for the decode stage: accepts one RV32 instruction word per cycle and returns its sign-extended immediate, detected format and a pass-through tag, one cycle later. Generalises the fixed 32-bit, four-format extender:
- XLEN-parametrised output.
- U-type support.
- Automatic format decode from the opcode, or an explicit format supplied by the main decoder.
- Illegal-format flag.
- Valid/ready flow control with a skid buffer, so back-pressure from execute never drops an instruction.

---
 rtl/imm_pkg.sv | 25 ++
 rtl/imm_decode.sv | 64 ++++++
 rtl/imm_gen_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format encoding and RV32 opcodes.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_J    = 3'd3,
    FMT_U    = 3'd4,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational format selection and immediate extraction for one instruction.
// Optional build macro IMMGEN_SHAMT_EN: shift-immediate instructions return a
// zero-extended shift amount instead of the plain I-type immediate.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic            auto_mode,
  input  logic [2:0]      fmt_sel,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  // Pick the format either from the opcode or from the main decoder.
  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (auto_mode) begin
      case (instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
        OP_STORE:         fmt = FMT_S;
        OP_BRANCH:        fmt = FMT_B;
        OP_JAL:           fmt = FMT_J;
        OP_LUI, OP_AUIPC: fmt = FMT_U;
        OP_REG:           fmt = FMT_NONE;
        default:          illegal = 1'b1;
      endcase
    end else begin
      case (fmt_sel)
        3'd0:       fmt = FMT_I;
        3'd1:       fmt = FMT_S;
        3'd2:       fmt = FMT_B;
        3'd3:       fmt = FMT_J;
        3'd4:       fmt = FMT_U;
        3'd5, 3'd6: illegal = 1'b1;
        default:    fmt = FMT_NONE;
      endcase
    end
  end

  // Assemble the immediate, sign-extended from instr[31] to XLEN.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      default: imm = '0;
    endcase
`ifdef IMMGEN_SHAMT_EN
    // slli/srli/srai (funct3 001/101): shift amount only, funct7 bits dropped.
    if (auto_mode && (instr[6:0] == OP_IMM) && (instr[13:12] == 2'b01)) begin
      if (XLEN == 64) imm = {{(XLEN-6){1'b0}}, instr[25:20]};
      else            imm = {{(XLEN-6){1'b0}}, 1'b0, instr[24:20]};
    end
`endif
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Handshaked immediate generator: one output register plus one skid entry so
// that a beat arriving while execute stalls is never lost. in_ready comes
// straight from the skid-occupancy flop.
// Optional build macro IMMGEN_SHAMT_EN (handled in imm_decode).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             in_auto,
  input  logic [2:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  entry_t          dec_p0;
  entry_t          entry_p1;
  entry_t          skid_p1;
  logic            vld_p1;
  logic            skid_vld_p1;
  logic            accept;
  logic            drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr     (in_instr),
    .auto_mode (in_auto),
    .fmt_sel   (in_fmt),
    .imm       (dec_imm),
    .fmt       (dec_fmt),
    .illegal   (dec_illegal)
  );

  assign dec_p0 = '{imm: dec_imm, fmt: dec_fmt, tag: in_tag, illegal: dec_illegal};

  assign in_ready = ~skid_vld_p1;
  assign accept   = in_valid & in_ready;
  assign drain    = vld_p1 & out_ready;

  // ---- stage p0 -> p1 : output register and skid occupancy ----
  // Skid refills the output first; otherwise a free or draining output takes
  // the new beat, and only a stalled full output pushes it into the skid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      entry_p1    <= '{imm: '0, fmt: FMT_NONE, tag: '0, illegal: 1'b0};
    end else if (drain && skid_vld_p1) begin
      entry_p1    <= skid_p1;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || drain) begin
      vld_p1 <= accept;
      if (accept) entry_p1 <= dec_p0;
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  // Skid payload is only meaningful while skid_vld_p1 is set.
  always_ff @(posedge clk) begin
    if (accept && vld_p1 && !drain) skid_p1 <= dec_p0;
  end

  assign out_valid   = vld_p1;
  assign out_imm     = entry_p1.imm;
  assign out_fmt     = entry_p1.fmt;
  assign out_tag     = entry_p1.tag;
  assign out_illegal = entry_p1.illegal;

endmodule
